// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio sample sequencer.
//   seq_state_t   : sequencer FSM states
//   audio_mid()   : PCM midpoint (silence) for a given sample width
//   MID           : midpoint for the default 8-bit sample width
//   scale_sample(): volume-scales an unsigned PCM sample around the midpoint
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    STARVED = 2'd2
  } seq_state_t;

  // Silence level of an unsigned PCM sample: 2^(width-1).
  function automatic int unsigned audio_mid(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

  localparam int unsigned AUDIO_BIT_WIDTH = 8;
  localparam int unsigned MID = audio_mid(AUDIO_BIT_WIDTH);

  // mid + ((sample - mid) * vol) >>> vw, with vol clamped to unity (2^vw).
  // With vol <= unity the result stays inside 0..2^bw-1.
  function automatic logic [31:0] scale_sample(input logic [31:0] sample,
                                               input logic [31:0] vol,
                                               input int unsigned bw,
                                               input int unsigned vw);
    logic [31:0]        vol_c;
    logic signed [63:0] s;
    logic signed [63:0] p;
    vol_c = (vol > (32'd1 << vw)) ? (32'd1 << vw) : vol;
    s     = $signed({32'd0, sample}) - $signed(64'(audio_mid(bw)));
    p     = (s * $signed({32'd0, vol_c})) >>> vw;
    return 32'(p + $signed(64'(audio_mid(bw))));
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO.
//   clk, rst   : clock, async active-high reset
//   push       : write request (ignored when full or flushing)
//   push_data  : write data
//   pop        : read request (ignored when empty or flushing)
//   flush      : empties the FIFO next cycle, voiding same-cycle push/pop
//   head_c     : current head entry (valid while !empty)
//   count      : registered occupancy
//   full/empty : registered occupancy flags
module audio_sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_n;
  logic             push_ok_c;
  logic             pop_ok_c;

  // Flags are registered, so a same-cycle pop never frees room for a push
  // and a push into an empty FIFO is not visible to pop until next cycle.
  assign push_ok_c = push && !full && !flush;
  assign pop_ok_c  = pop && !empty && !flush;
  assign head_c    = mem[rd_ptr];

  // Next occupancy
  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else if (push_ok_c && !pop_ok_c) begin
      count_n = count + CNT_W'(1);
    end else if (!push_ok_c && pop_ok_c) begin
      count_n = count - CNT_W'(1);
    end
  end

  // Pointers and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_n;
      full  <= (count_n == CNT_W'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/audio_sample_sequencer.sv
// Audio sample sequencer: buffers CPU-written PCM samples and feeds them to
// pwm_generator as its duty, committing changes only on PWM period boundaries.
// Optional volume scaling is built when AUDIO_VOLUME_EN is defined; otherwise
// duty = {0, sample} and the volume port is ignored.
//   clk, rst      : clock shared with pwm_generator, async active-high reset
//   enable        : playback running
//   flush         : sync pulse, empties the FIFO
//   sample_div    : sample tick every sample_div+1 PWM periods
//   volume        : gain, unity = 2^VOL_W
//   wr_valid/wr_data/wr_ready : sample write handshake
//   fifo_count    : FIFO occupancy
//   underrun      : sticky, a tick found the FIFO empty; underrun_clr clears
//   duty          : to pwm_generator.duty
module audio_sample_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned VOL_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [DIV_W-1:0]            sample_div,
  input  logic [VOL_W:0]              volume,
  input  logic                        wr_valid,
  input  logic [BIT_WIDTH-1:0]        wr_data,
  output logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        underrun,
  input  logic                        underrun_clr,
  output logic [BIT_WIDTH:0]          duty
);

  localparam int unsigned      DUTY_W   = BIT_WIDTH + 1;
  localparam logic [DUTY_W-1:0] DUTY_MID = DUTY_W'(audio_mid(BIT_WIDTH));

  seq_state_t           state;
  seq_state_t           state_n;
  logic [BIT_WIDTH-1:0] phase;
  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_cnt_n;
  logic [DUTY_W-1:0]    duty_n;
  logic                 underrun_n;
  logic                 boundary_c;
  logic                 tick_c;
  logic                 pop_c;
  logic [BIT_WIDTH-1:0] head_c;
  logic [DUTY_W-1:0]    scaled_c;
  logic                 fifo_full;
  logic                 fifo_empty;

  audio_sample_fifo #(
    .WIDTH (BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop_c),
    .flush     (flush),
    .head_c    (head_c),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_ready = ~fifo_full;

  // Last clock of a PWM period: a duty registered here applies from pwm counter 0.
  assign boundary_c = &phase;
  assign tick_c     = boundary_c && enable && (div_cnt == '0);

`ifdef AUDIO_VOLUME_EN
  assign scaled_c = DUTY_W'(scale_sample(32'(head_c), 32'(volume), BIT_WIDTH, VOL_W));
`else
  logic unused_volume;
  assign unused_volume = ^volume;
  assign scaled_c      = {1'b0, head_c};
`endif

  // Next state, duty, underrun and divider
  always_comb begin
    state_n    = state;
    duty_n     = duty;
    underrun_n = underrun;
    div_cnt_n  = div_cnt;
    pop_c      = 1'b0;

    if (underrun_clr) underrun_n = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      if (boundary_c) duty_n = DUTY_MID;
    end else begin
      case (state)
        IDLE: begin
          state_n = PLAY;
          if (boundary_c) duty_n = DUTY_MID;
        end
        PLAY, STARVED: begin
          if (tick_c) begin
            // A flush voids the pop: treat the FIFO as empty for this tick.
            if (!fifo_empty && !flush) begin
              pop_c   = 1'b1;
              duty_n  = scaled_c;
              state_n = PLAY;
            end else begin
              duty_n = DUTY_MID;
              if (state == PLAY) begin
                underrun_n = 1'b1;
                state_n    = STARVED;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (!enable) begin
      div_cnt_n = '0;
    end else if (tick_c) begin
      div_cnt_n = sample_div;
    end else if (boundary_c && (div_cnt != '0)) begin
      div_cnt_n = div_cnt - DIV_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      div_cnt  <= '0;
      duty     <= DUTY_MID;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase + BIT_WIDTH'(1);
      div_cnt  <= div_cnt_n;
      duty     <= duty_n;
      underrun <= underrun_n;
    end
  end

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Self-checking bench for audio_sample_sequencer (BIT_WIDTH=8, 256-clock PWM period).
// A behavioural model written from the playback rules runs alongside the DUT and
// is compared every clock; hand-written sequences and a vector table add fixed checks.
module tb_audio_sample_sequencer;

  localparam int BW     = 8;
  localparam int DEPTH  = 16;
  localparam int PERIOD = 256;
  localparam int MID    = 128;
  localparam int VOL_W  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] sample_div = 8'd0;
  logic [8:0] volume = 9'd256;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_ready;
  logic [4:0] fifo_count;
  logic       underrun;
  logic       underrun_clr = 1'b0;
  logic [8:0] duty;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural model state
  localparam int M_IDLE = 0, M_PLAY = 1, M_STARVED = 2;
  logic [7:0] m_q[$];
  int m_mode, m_phase, m_div, m_duty;
  bit m_underrun;

  audio_sample_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .flush        (flush),
    .sample_div   (sample_div),
    .volume       (volume),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .fifo_count   (fifo_count),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .duty         (duty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "time limit");
  end

  function automatic int ref_scale(input int smp);
`ifdef AUDIO_VOLUME_EN
    int v;
    v = (int'(volume) > 256) ? 256 : int'(volume);
    return MID + (((smp - MID) * v) >>> VOL_W);
`else
    return smp;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE;
    m_phase = 0;
    m_div = 0;
    m_duty = MID;
    m_underrun = 1'b0;
  endtask

  // One clock of playback rules, using the inputs present at the edge.
  task automatic model_step();
    int sz;
    bit bnd, tick, popped;
    sz = m_q.size();
    bnd = (m_phase == PERIOD - 1);
    tick = bnd && enable && (m_div == 0);
    popped = 1'b0;
    if (underrun_clr) m_underrun = 1'b0;
    if (!enable) begin
      m_mode = M_IDLE;
      if (bnd) m_duty = MID;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_PLAY;
      if (bnd) m_duty = MID;
    end else if (tick) begin
      if (sz > 0 && !flush) begin
        m_duty = ref_scale(int'(m_q[0]));
        popped = 1'b1;
        m_mode = M_PLAY;
      end else begin
        m_duty = MID;
        if (m_mode == M_PLAY) begin
          m_underrun = 1'b1;
          m_mode = M_STARVED;
        end
      end
    end
    if (!enable) m_div = 0;
    else if (tick) m_div = int'(sample_div);
    else if (bnd) m_div = m_div - 1;
    if (flush) begin
      m_q.delete();
    end else begin
      if (popped) void'(m_q.pop_front());
      if (wr_valid && sz < DEPTH) m_q.push_back(wr_data);
    end
    m_phase = (m_phase + 1) % PERIOD;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Advance one clock, step the model, then compare all outputs against it.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step();
      cyc++;
    end
    #1;
    if (!rst) begin
      checks++;
      if (int'(duty) != m_duty || int'(fifo_count) != m_q.size() ||
          wr_ready != (m_q.size() < DEPTH) || underrun != m_underrun) begin
        failures++;
        $display("FAIL model: cyc=%0d duty=%0d/%0d count=%0d/%0d ready=%0b/%0b underrun=%0b/%0b (got/expected)",
                 cyc, duty, m_duty, fifo_count, m_q.size(), wr_ready, (m_q.size() < DEPTH),
                 underrun, m_underrun);
        if (failures > 40) begin
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $finish;
        end
      end
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) cycle();
  endtask

  // Asynchronous reset applied between clock edges; optionally checks reset values at once.
  task automatic do_reset(input bit chk);
    #3;
    rst = 1'b1;
    #1;
    if (chk) begin
      check("rst_duty", int'(duty), MID);
      check("rst_underrun", int'(underrun), 0);
      check("rst_count", int'(fifo_count), 0);
      check("rst_ready", int'(wr_ready), 1);
    end
    enable = 1'b0; flush = 1'b0; wr_valid = 1'b0; underrun_clr = 1'b0;
    sample_div = 8'd0; volume = 9'd256;
    cycle();
    cycle();
    rst = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  task automatic write(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  typedef struct {
    bit         wv;
    logic [7:0] wd;
    bit         fl;
    int         exp_cnt;
    int         exp_rdy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    for (int i = 0; i < 17; i++) tbl[i] = '{1'b1, 8'(i * 7 + 1), 1'b0, (i < 16) ? i + 1 : 16, (i + 1 < 16) ? 1 : 0};
    tbl[17] = '{1'b1, 8'hAA, 1'b1, 0, 1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 0, 1};

    model_reset();
    do_reset(1'b0);

    // Three samples at one per period, then underrun; set wins over a same-cycle clear.
    write(8'h10); write(8'h20); write(8'h30);
    enable = 1'b1;
    run_to(255);  check("t2_pre", int'(duty), MID);
    run_to(256);  check("t2_s0", int'(duty), 16);  check("t2_cnt", int'(fifo_count), 2);
    run_to(511);  check("t2_hold", int'(duty), 16);
    run_to(512);  check("t2_s1", int'(duty), 32);
    run_to(768);  check("t2_s2", int'(duty), 48);
    run_to(1023); check("t2_noun", int'(underrun), 0);
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    check("t2_mid", int'(duty), MID); check("t2_under", int'(underrun), 1);
    // Recover from starvation, then reset mid-playback.
    write(8'h40); write(8'h50);
    run_to(1300);
    check("t1_pre_duty", int'(duty), 64); check("t1_pre_cnt", int'(fifo_count), 1);
    do_reset(1'b1);

    // sample_div=3: each sample held four periods.
    write(8'h11); write(8'h22);
    sample_div = 8'd3;
    enable = 1'b1;
    run_to(256);  check("t3_s0", int'(duty), 17);
    run_to(1279); check("t3_hold", int'(duty), 17);
    run_to(1280); check("t3_s1", int'(duty), 34);
    run_to(2303); check("t3_hold1", int'(duty), 34);
    run_to(2304); check("t3_mid", int'(duty), MID); check("t3_under", int'(underrun), 1);
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    check("t3_clr", int'(underrun), 0);
    do_reset(1'b0);

    // Fill past full without playing, then flush with a same-cycle write.
    for (int i = 0; i < 19; i++) begin
      wr_valid = tbl[i].wv;
      wr_data = tbl[i].wd;
      flush = tbl[i].fl;
      cycle();
      check($sformatf("t4_cnt[%0d]", i), int'(fifo_count), tbl[i].exp_cnt);
      check($sformatf("t4_rdy[%0d]", i), int'(wr_ready), tbl[i].exp_rdy);
    end
    wr_valid = 1'b0; flush = 1'b0;
    do_reset(1'b0);

    // Drop enable mid-sample, then resume from the FIFO head.
    write(8'h60); write(8'h70); write(8'h80);
    enable = 1'b1;
    run_to(256); check("t5_s0", int'(duty), 96); check("t5_cnt0", int'(fifo_count), 2);
    run_to(300); enable = 1'b0;
    run_to(511); check("t5_hold", int'(duty), 96);
    run_to(512); check("t5_mid", int'(duty), MID); check("t5_cnt1", int'(fifo_count), 2);
    run_to(600); enable = 1'b1;
    run_to(767); check("t5_idle", int'(duty), MID);
    run_to(768); check("t5_s1", int'(duty), 112); check("t5_cnt2", int'(fifo_count), 1);
    do_reset(1'b0);

    // Volume scaling (identity when the feature is not built).
    volume = 9'd128;
    write(8'hFF); write(8'h00); write(8'hFF);
    enable = 1'b1;
`ifdef AUDIO_VOLUME_EN
    run_to(256); check("t6_ff_half", int'(duty), 191);
    run_to(512); check("t6_00_half", int'(duty), 64);
`else
    run_to(256); check("t6_ff_raw", int'(duty), 255);
    run_to(512); check("t6_00_raw", int'(duty), 0);
`endif
    volume = 9'd300;
    run_to(768); check("t6_ff_clamp", int'(duty), 255);
    do_reset(1'b0);

    // Randomized traffic in segments of differing write pressure.
    enable = 1'b1;
    for (int seg = 0; seg < 4; seg++) begin
      int rate;
      rate = (seg == 0) ? 3 : (seg == 1) ? 40 : (seg == 2) ? 0 : 1;
      for (int n = 0; n < 3000; n++) begin
        wr_valid = ($urandom_range(0, 99) < rate);
        wr_data = 8'($urandom);
        flush = ($urandom_range(0, 1999) == 0);
        underrun_clr = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 1499) == 0) enable = ~enable;
        if ($urandom_range(0, 499) == 0) sample_div = 8'($urandom_range(0, 2));
        if ($urandom_range(0, 399) == 0) volume = 9'($urandom_range(0, 300));
        cycle();
      end
    end
    wr_valid = 1'b0; flush = 1'b0; underrun_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
